adat_rx_tdm8_tx: RTL
====================

Name: adat_rx_tdm8_tx

Overview:
- Downstream consumer of adat_rx_adat_rx. Latches one decoded ADAT frame (8 × 24-bit channels) on each o_valid pulse.
- Re-emits the frame as an 8-slot TDM serial burst (BCLK/FSYNC/SDATA, 32-bit slots, MSB-first, left-justified) for a codec or DSP.
- Double-buffered: one frame can queue while the previous burst is shifting out. Loss of lock aborts output cleanly.

Parameters:
- BCLK_DIV, 8, i_clk cycles per BCLK period; even, ≥2. A burst lasts 256·BCLK_DIV cycles and must be shorter than the frame period (2048 < 2083 at 100 MHz / 48 kHz).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; asynchronous, active-low
- i_channels  in  8×24  decoded channel data; index 0 = slot 0
- i_valid  in  1  one-cycle strobe; i_channels valid in this cycle
- i_valid_channels  in  4  number of active channels (8 normal, 4 S/MUX2); values >8 treated as 8
- i_locked  in  1  receiver lock
- o_bclk  out  1  TDM bit clock
- o_fsync  out  1  frame sync; high for the whole bit period of slot 0 bit 0
- o_sdata  out  1  serial data
- o_busy  out  1  burst in progress
- o_overrun  out  1  one-cycle pulse: a pending frame was overwritten

Behaviour:
- Reset (i_rst=0, async): all outputs 0; state IDLE; pending flag cleared; counters cleared.
- Storage:
  - active buffer: 8×24 plus a 4-bit mask count;
  - pending buffer: same contents plus a pending flag.
- State IDLE:
  - i_valid & i_locked → copy i_channels and i_valid_channels into the active buffer; div_cnt=0, bit_cnt=0; go to RUN.
  - Outputs take frame values from the next cycle: 1-cycle latency from i_valid to the first o_fsync=1.
- State RUN:
  - div_cnt counts 0..BCLK_DIV-1. o_bclk=0 while div_cnt<BCLK_DIV/2, 1 otherwise. o_sdata and o_fsync update only when div_cnt==0 (BCLK falling edge); the sink samples on the rising edge.
  - bit_cnt counts 0..255 and advances when div_cnt wraps. slot=bit_cnt[7:5], pos=bit_cnt[4:0].
  - o_sdata = active[slot][23-pos] if pos<24 and slot<mask; otherwise 0.
  - o_fsync = 1 iff bit_cnt==0.
  - o_busy = 1 throughout RUN.
- End of burst (bit_cnt==255 and div_cnt==BCLK_DIV-1):
  - pending set → move pending into active, clear pending, restart at bit_cnt=0 with no idle gap;
  - pending clear → go to IDLE; o_bclk, o_sdata, o_fsync, o_busy = 0.
- i_valid & i_locked during RUN:
  - write the pending buffer and set pending;
  - if pending was already set, overwrite it and pulse o_overrun for 1 cycle.
- Simultaneous i_valid with end of burst:
  - the old pending is promoted to active;
  - the new data goes to pending;
  - no o_overrun.
  - If no old pending exists, the new data becomes active directly.
- i_valid while i_locked=0: ignored.
- i_locked falling in any state:
  - next cycle: state IDLE, pending cleared, all serial outputs and o_busy = 0, counters cleared;
  - no o_overrun.
- Reset asserted mid-burst: immediate return to reset values. After release, waits for a fresh i_valid.
- Active data does not change during a burst; i_channels is sampled only on i_valid.

Test Plan:
- Single frame: ch0=0x123456 … ch7=0xABCDEF, mask 8, BCLK_DIV=8, one i_valid.
  → o_fsync high for cycles 1–8; slot 0 shifts 0x123456 then 8 zeros; total 256 BCLK rising edges; o_busy falls at cycle 2049.
- S/MUX2 mask: i_valid_channels=4, ch4..7 = 0xCC0000, 0xCC1111, 0xDD0000, 0xDD1111.
  → slots 0–3 carry data; slots 4–7 are all zeros.
- Back-to-back frames: second i_valid at cycle 1000 (data A), third at cycle 1500 (data B).
  → o_overrun pulses once at cycle 1501; the second burst carries B with no gap (o_fsync at cycle 2049).
- End-of-burst collision: i_valid exactly on the final cycle with no pending data.
  → the new frame starts the next cycle; o_busy stays 1; no o_overrun.
- Lock loss: i_locked→0 at bit 100.
  → next cycle all outputs 0 and pending dropped; a later i_valid with i_locked=0 produces no burst.
- Async reset mid-burst: i_rst low between clock edges.
  → outputs 0 immediately, without waiting for a clock edge; after release, the next i_valid produces a full, correct burst.

Source files
------------

// File: rtl/adat_rx_tdm8_tx.sv
// ADAT frame to 8-slot TDM serializer.
// One decoded ADAT frame (8 x 24-bit channels) is latched on each i_valid.
// The frame is re-emitted as a 256-bit TDM burst: 32-bit slots, MSB-first,
// left-justified, with FSYNC high for the bit period of slot 0 bit 0.
// A second frame can wait in a pending buffer while the current burst shifts.
// If the pending frame is overwritten, o_overrun pulses.
// Loss of lock drops everything back to idle.
`timescale 1ns/1ps

module adat_rx_tdm8_tx #(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0][23:0] i_channels,
  input  logic             i_valid,
  input  logic [3:0]       i_valid_channels,
  input  logic             i_locked,
  output logic             o_bclk,
  output logic             o_fsync,
  output logic             o_sdata,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0][23:0] active_q, active_d;
  logic [3:0]       act_mask_q, act_mask_d;
  logic [7:0][23:0] pend_q, pend_d;
  logic [3:0]       pend_mask_q, pend_mask_d;
  logic             pend_vld_q, pend_vld_d;
  logic             overrun_q, overrun_d;

  logic       take;
  logic       burst_end;
  logic [3:0] in_mask;
  logic [2:0] slot;
  logic [4:0] pos;
  logic [4:0] bit_idx;

  assign take      = i_valid & i_locked;
  assign burst_end = (state_q == ST_RUN) && (bit_cnt_q == 8'hFF) && (div_cnt_q == DIV_LAST);
  assign in_mask   = (i_valid_channels > 4'd8) ? 4'd8 : i_valid_channels;

  // Next-state logic: counters, buffer hand-over, pending/overrun bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    active_d    = active_q;
    act_mask_d  = act_mask_q;
    pend_d      = pend_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;
    overrun_d   = 1'b0;

    if (!i_locked) begin
      state_d    = ST_IDLE;
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      pend_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            active_d   = i_channels;
            act_mask_d = in_mask;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          // Bit counter wraps 255 -> 0 on its own, so a chained burst restarts at bit 0.
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + 8'd1;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end

          if (burst_end) begin
            if (pend_vld_q) begin
              active_d   = pend_q;
              act_mask_d = pend_mask_q;
              pend_vld_d = take;
              if (take) begin
                pend_d      = i_channels;
                pend_mask_d = in_mask;
              end
            end else if (take) begin
              active_d   = i_channels;
              act_mask_d = in_mask;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (take) begin
            pend_d      = i_channels;
            pend_mask_d = in_mask;
            pend_vld_d  = 1'b1;
            overrun_d   = pend_vld_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      act_mask_q <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      act_mask_q <= act_mask_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  // Frame data buffers; contents are only observed while a burst is running.
  always_ff @(posedge i_clk) begin
    // NOTE: data buffers are deliberately not reset; validity is tracked by state_q and pend_vld_q.
    active_q    <= active_d;
    pend_q      <= pend_d;
    pend_mask_q <= pend_mask_d;
  end

  // Serial outputs are decoded from registered counters, so they change only at
  // div_cnt==0 (BCLK falling) and drop to 0 as soon as reset or idle is reached.
  always_comb begin
    slot    = bit_cnt_q[7:5];
    pos     = bit_cnt_q[4:0];
    bit_idx = 5'd23 - pos;
    o_busy  = (state_q == ST_RUN);
    o_bclk  = o_busy && (div_cnt_q >= DIV_HALF);
    o_fsync = o_busy && (bit_cnt_q == 8'd0);
    o_sdata = 1'b0;
    if (o_busy && (pos < 5'd24) && ({1'b0, slot} < act_mask_q)) begin
      o_sdata = active_q[slot][bit_idx];
    end
  end

  assign o_overrun = overrun_q;

endmodule
